id_stage_pipe: RTL
==================

// Module: id_stage_pipe
// PURPOSE
//  Parametrised decode stage: register file, opcode decode, immediate generation, ID/EX pipeline register.
//  Sits between IF (valid/ready) and EX (valid/ready). Adds backpressure, flush, load-use interlock, illegal detect.
//  One-cycle latency from IF accept to ex_valid.
// PARAMETERS
//  XLEN   32  datapath / register width
//  NREG   32  architectural registers (32 = RV32I, 16 = RV32E); x0 hardwired to 0
//  PC_W   32  program counter width
// PORTS
//  clk          in   1        clock, all state on rising edge
//  rst          in   1        asynchronous, active-low reset
//  if_valid     in   1        IF presents instruction
//  if_ready     out  1        ID accepts this cycle (combinational)
//  if_pc        in   PC_W     PC of presented instruction
//  if_instr     in   32       presented instruction
//  flush        in   1        squash ID/EX contents and current IF beat
//  wb_we        in   1        writeback enable
//  wb_addr      in   5        writeback register
//  wb_data      in   XLEN     writeback data
//  ex_valid     out  1        ID/EX register holds a live instruction
//  ex_ready     in   1        EX consumes ID/EX this cycle
//  ex_pc        out  PC_W     registered PC
//  ex_rs1_data  out  XLEN     registered rs1 value
//  ex_rs2_data  out  XLEN     registered rs2 value
//  ex_imm       out  XLEN     sign-extended immediate
//  ex_rs1_addr / ex_rs2_addr / ex_rd_addr  out  5 each
//  ex_funct3    out  3   ;  ex_funct7  out  7
//  ex_alu_op    out  3   ;  ex_branch  out  2
//  ex_alu_src / ex_mem_read / ex_mem_write / ex_reg_write / ex_csr_write / ex_illegal  out  1 each
// BEHAVIOUR
//  - Reset (rst=0): every ex_* output 0, all registers 0; if_ready follows its equation (true once out of reset).
//  - hazard = ex_valid & ex_mem_read & ex_rd_addr!=0 & (ex_rd_addr==rs1 | ex_rd_addr==rs2); rs1/rs2 from if_instr.
//  - if_ready = rst & !hazard & (!ex_valid | ex_ready).
//  - ID/EX load: if_valid & if_ready -> capture decode of if_instr, ex_valid<=1 (unless flush).
//  - Drain w/o refill: ex_ready & !(if_valid & if_ready) -> ex_valid<=0 (bubble); ex_* payload may hold.
//  - Stall: ex_valid & !ex_ready -> ID/EX frozen, if_ready=0.
//  - FSM (2 states): RUN -> INTERLOCK when hazard & ex_ready (load leaves, bubble inserted);
//    INTERLOCK -> RUN next cycle (load no longer in ID/EX, instruction re-evaluated and accepted).
//  - flush: ex_valid<=0 next edge, FSM->RUN, IF beat accepted and dropped; flush beats stall and hazard.
//  - Register file: NREG x XLEN, 2 read / 1 write; write on wb_we & wb_addr!=0 & wb_addr<NREG.
//    Writeback proceeds regardless of flush/stall.
//  - Immediates by type: I,S,B,U,J per RV32 base; B/J LSB 0; sign-extended from instr[31] to XLEN.
//  - Illegal: unknown opcode, or any used register index >= NREG -> ex_illegal=1, ex_reg_write/ex_mem_*=0.
//  - Control decode identical in encoding to the team's existing control unit (ALUOP, Branch, CSR_write).
// CONFIGURATION
//  ID_RF_BYPASS_EN defined: same-cycle wb to rs1/rs2 of the accepted instruction forwards wb_data
//    into ex_rs*_data (write-through); x0 never bypassed.
//  Undefined: register read returns pre-write value; forwarding in EX/WB must cover this case.
// TESTING
//  1 rst low mid-stream -> all ex_* 0 asynchronously; after release first addi accepted, ex_valid next cycle.
//  2 addi x5,x0,-1 (0xFFF00293) -> ex_imm=0xFFFFFFFF, ex_rd_addr=5, ex_alu_src=1, ex_reg_write=1.
//  3 lw x6,0(x1) then add x7,x6,x2 -> one bubble (ex_valid=0 one cycle), add issues after; no hazard if rd=x0.
//  4 ex_ready=0 for 3 cycles with if_valid=1 -> if_ready=0, ex_* stable; ex_ready=1 -> next instr loads.
//  5 flush with load in ID/EX and hazard pending -> ex_valid=0 next cycle, FSM RUN, IF beat dropped.
//  6 wb x9=0x1234 same cycle add reads x9: bypass build -> ex_rs1_data=0x1234; plain -> old x9.
//    NREG=16: add x20,.. -> ex_illegal=1, ex_reg_write=0.

Source files
------------

// File: rtl/id_stage_pipe.sv
// Decode stage: 2R/1W register file, RV32 opcode decode, immediate generation and ID/EX register.
// Define ID_RF_BYPASS_EN to forward a same-cycle writeback into the captured rs1/rs2 data.
module id_stage_pipe #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [PC_W-1:0] if_pc,
  input  logic [31:0]     if_instr,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [PC_W-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1_addr,
  output logic [4:0]      ex_rs2_addr,
  output logic [4:0]      ex_rd_addr,
  output logic [2:0]      ex_funct3,
  output logic [6:0]      ex_funct7,
  output logic [2:0]      ex_alu_op,
  output logic [1:0]      ex_branch,
  output logic            ex_alu_src,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            ex_csr_write,
  output logic            ex_illegal
);

  localparam int          AW     = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int unsigned NREG_U = NREG;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_BR  = 3'd1;
  localparam logic [2:0] ALU_R   = 3'd2;
  localparam logic [2:0] ALU_I   = 3'd3;
  localparam logic [2:0] ALU_LUI = 3'd4;
  localparam logic [2:0] ALU_SYS = 3'd5;

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_COND = 2'd1;
  localparam logic [1:0] BR_JAL  = 2'd2;
  localparam logic [1:0] BR_JALR = 2'd3;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [2:0]      alu_op;
    logic [1:0]      branch;
    logic            alu_src;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            csr_write;
    logic            illegal;
  } ex_t;

  typedef enum logic {RUN, INTERLOCK} state_t;

  function automatic logic in_range(input logic [4:0] a);
    return 32'(a) < NREG_U;
  endfunction

  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];
  ex_t             ex_q, ex_d, dec;
  logic            ex_valid_q, ex_valid_d;
  state_t          state_q, state_d;
  logic            hazard_en, hazard, accept, wb_hit;
  logic            use_rs1, use_rs2, use_rd, known;
  logic [31:0]     imm32;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [4:0]      rs1, rs2;

  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];
  assign wb_hit = wb_we && (wb_addr != 5'd0) && in_range(wb_addr);

  always_comb begin
    rf_d = rf_q;
    if (wb_hit) rf_d[wb_addr[AW-1:0]] = wb_data;
  end

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if ((rs1 != 5'd0) && in_range(rs1)) rs1_val = rf_q[rs1[AW-1:0]];
    if ((rs2 != 5'd0) && in_range(rs2)) rs2_val = rf_q[rs2[AW-1:0]];
`ifdef ID_RF_BYPASS_EN
    if (wb_hit && (wb_addr == rs1)) rs1_val = wb_data;
    if (wb_hit && (wb_addr == rs2)) rs2_val = wb_data;
`endif
  end

  always_comb begin
    dec          = '0;
    imm32        = '0;
    known        = 1'b1;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    use_rd       = 1'b0;
    dec.pc       = if_pc;
    dec.rs1_data = rs1_val;
    dec.rs2_data = rs2_val;
    dec.rs1_addr = rs1;
    dec.rs2_addr = rs2;
    dec.rd_addr  = if_instr[11:7];
    dec.funct3   = if_instr[14:12];
    dec.funct7   = if_instr[31:25];
    unique case (if_instr[6:0])
      OPC_OP: begin
        dec.alu_op = ALU_R; dec.reg_write = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.alu_op = ALU_I; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
        imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
        use_rs1 = 1'b1; use_rd = 1'b1;
      end
      OPC_LOAD: begin
        dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.mem_read = 1'b1; dec.reg_write = 1'b1;
        imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
        use_rs1 = 1'b1; use_rd = 1'b1;
      end
      OPC_STORE: begin
        dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.mem_write = 1'b1;
        imm32 = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        dec.alu_op = ALU_BR; dec.branch = BR_COND;
        imm32 = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_LUI: begin
        dec.alu_op = ALU_LUI; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
        imm32 = {if_instr[31:12], 12'b0};
        use_rd = 1'b1;
      end
      OPC_AUIPC: begin
        dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
        imm32 = {if_instr[31:12], 12'b0};
        use_rd = 1'b1;
      end
      OPC_JAL: begin
        dec.alu_op = ALU_ADD; dec.branch = BR_JAL; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
        imm32 = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};
        use_rd = 1'b1;
      end
      OPC_JALR: begin
        dec.alu_op = ALU_ADD; dec.branch = BR_JALR; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
        imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
        use_rs1 = 1'b1; use_rd = 1'b1;
      end
      OPC_SYSTEM: begin
        dec.alu_op = ALU_SYS;
        imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
        // funct3==0 is ECALL/EBREAK; CSR-immediate forms (funct3[2]) carry no rs1
        if (if_instr[14:12] != 3'd0) begin
          dec.csr_write = 1'b1; dec.reg_write = 1'b1;
          use_rd  = 1'b1;
          use_rs1 = ~if_instr[14];
        end
      end
      default: known = 1'b0;
    endcase
    dec.imm     = XLEN'($signed(imm32));
    dec.illegal = ~known | (use_rs1 & ~in_range(rs1)) | (use_rs2 & ~in_range(rs2))
                | (use_rd & ~in_range(if_instr[11:7]));
    if (dec.illegal) begin
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.csr_write = 1'b0;
    end
  end

  // Interlock FSM: next-state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:       if (hazard && ex_ready) state_d = INTERLOCK;
      INTERLOCK: state_d = RUN;
      default:   state_d = RUN;
    endcase
    if (flush) state_d = RUN;
  end

  // Interlock FSM: outputs; ID/EX is always empty in INTERLOCK, so masking is redundant but explicit
  always_comb begin
    hazard_en = (state_q == RUN);
  end

  assign hazard = hazard_en & ex_valid_q & ex_q.mem_read & (ex_q.rd_addr != 5'd0)
                & ((ex_q.rd_addr == rs1) | (ex_q.rd_addr == rs2));
  assign if_ready = rst & (flush | (~hazard & (~ex_valid_q | ex_ready)));
  assign accept   = if_valid & if_ready;

  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      ex_d       = dec;
      ex_valid_d = 1'b1;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG_U; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_pc        = ex_q.pc;
  assign ex_rs1_data  = ex_q.rs1_data;
  assign ex_rs2_data  = ex_q.rs2_data;
  assign ex_imm       = ex_q.imm;
  assign ex_rs1_addr  = ex_q.rs1_addr;
  assign ex_rs2_addr  = ex_q.rs2_addr;
  assign ex_rd_addr   = ex_q.rd_addr;
  assign ex_funct3    = ex_q.funct3;
  assign ex_funct7    = ex_q.funct7;
  assign ex_alu_op    = ex_q.alu_op;
  assign ex_branch    = ex_q.branch;
  assign ex_alu_src   = ex_q.alu_src;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_csr_write = ex_q.csr_write;
  assign ex_illegal   = ex_q.illegal;

endmodule
